keypad_key_emulator: RTL
========================

// Module: keypad_key_emulator
// PURPOSE
//  Synthesizable far-end model of the 4x4 hex keypad matrix: it is the key side of the scanner's col/row interface.
//  - Accepts key-press requests (4-bit key index) over a valid/ready handshake.
//  - Holds the contact closed for a programmed time, then a release gap, and signals completion.
//  - Drives row lines as a function of the scanner's col drive, as a real switch matrix would.
//  - Sits between a stimulus source (bench, UART command decoder) and the keypad scanner plus its row synchronizer.
// PARAMETERS
//  HOLD_CYCLES    6  clock cycles the contact is closed per press; must be >=1
//  GAP_CYCLES     2  clock cycles of forced release after each press; 0 is allowed
//  BOUNCE_CYCLES  4  length of the bounce window at press start; used only with KEYPAD_BOUNCE_EN
//  CNT_W          8  timer width; must hold max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES)
// PORTS
//  clock      in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high reset
//  key_code   in   4  key index 0..F to press
//  key_valid  in   1  request strobe; accepted when key_valid & key_ready
//  key_ready  out  1  high only in IDLE
//  col        in   4  column drive from the scanner, active-high
//  row        out  4  row sense to the scanner/synchronizer, active-high
//  busy       out  1  high in PRESS or GAP
//  done       out  1  one-cycle pulse when a press/release sequence completes
// BEHAVIOUR
//  Reset values (asynchronous): state=IDLE, latched key=0, contact=0, timer=0, done=0.
//   Outputs: row=0, key_ready=1, busy=0.
//  Matrix mapping: key k closes the switch between col[k[1:0]] and row[k[3:2]].
//   row[i] = contact & (key[3:2]==i) & col[key[1:0]]
//   row is combinational from col and registered state, with no clock delay on col.
//  FSM states: IDLE, PRESS, GAP.
//  IDLE
//   - On key_valid & key_ready: latch key_code, timer=0, go to PRESS.
//   - key_code is ignored when key_valid is low.
//  PRESS
//   - contact=1 for exactly HOLD_CYCLES cycles, starting the cycle after accept.
//   - Then: if GAP_CYCLES>0 go to GAP, else go to IDLE.
//  GAP
//   - contact=0 for exactly GAP_CYCLES cycles, then go to IDLE.
//  done
//   - Registered; high for exactly the first IDLE cycle after PRESS/GAP completes.
//  Throughput: one press per 1+HOLD_CYCLES+GAP_CYCLES cycles, back to back.
//   A new request may be accepted in the same cycle done is high.
//  key_valid while busy: not accepted; the requester must hold it. No queueing, no loss of the in-flight key.
//  key_code changing during PRESS/GAP has no effect, because the key is latched.
//  col=0 or col not matching the key column gives row=0 even with contact=1.
//  Multiple col bits high gives row per the formula; only one row bit can ever be set.
//  Reset mid-press: row drops to 0 asynchronously; the sequence is aborted and done is not pulsed.
//  Timer saturates and never wraps; out-of-range parameters are a configuration error (checked in simulation).
// CONFIGURATION
//  KEYPAD_BOUNCE_EN defined:
//   - During the first BOUNCE_CYCLES cycles of PRESS, contact toggles every cycle, starting at 1.
//   - The bounce window counts inside HOLD_CYCLES, so total PRESS length is unchanged.
//   - If BOUNCE_CYCLES>=HOLD_CYCLES, the whole press bounces.
//  KEYPAD_BOUNCE_EN undefined:
//   - contact is a clean 1 for all of PRESS.
//   - BOUNCE_CYCLES is unused; no bounce logic is synthesized.
// TESTING
//  1. Assert reset, then release -> row=0, key_ready=1, busy=0, done=0.
//  2. key_code=5, col=0010, valid 1 cycle -> next 6 cycles row=0010; with col=0001, row=0000.
//     Then 2 cycles row=0, then done=1 for 1 cycle.
//  3. key_code=F then key_code=0, valid held high -> second accept in the done cycle.
//     Accepts are 9 cycles apart; row follows col[3]->row[3], then col[0]->row[0].
//  4. Assert reset at PRESS cycle 3 with key A, col=0100 -> row goes 0100->0000 immediately.
//     No done pulse; key_ready=1.
//  5. With KEYPAD_BOUNCE_EN, key 0, col=0001 -> row[0] = 1,0,1,0,1,1 over the 6 PRESS cycles.
//  6. Drive all 16 keys through the keypad scanner -> each scanner code equals the request key_code, once per press.

Source files
------------

// File: rtl/keypad_key_emulator.sv
// Key-side model of a 4x4 hex keypad: presses a requested key for a timed hold, then a release gap.
// Optional contact bounce at press start is enabled with the KEYPAD_BOUNCE_EN macro.
module keypad_key_emulator #(
  parameter int HOLD_CYCLES   = 6,
  parameter int GAP_CYCLES    = 2,
  parameter int BOUNCE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Bad timing parameters stop elaboration rather than silently misbehaving.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2**CNT_W) - 1 ||
      GAP_CYCLES < 0 || GAP_CYCLES > (2**CNT_W) - 1 ||
      BOUNCE_CYCLES < 0 || BOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_cfg_err
    $error("keypad_key_emulator: timing parameters out of range for CNT_W");
  end

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic [3:0]       r_key, w_key_nxt;
  logic             r_done, w_done_nxt;
  logic             w_contact;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_key   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_key   <= w_key_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_key_nxt   = r_key;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_valid) begin
          w_key_nxt   = key_code;
          w_timer_nxt = '0;
          w_state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (r_timer >= HOLD_LAST) begin
          w_timer_nxt = '0;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_timer_nxt = sat_inc(r_timer);
        end
      end
      GAP: begin
        if (r_timer >= GAP_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_timer_nxt = sat_inc(r_timer);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

`ifdef KEYPAD_BOUNCE_EN
  // Timer counts PRESS cycles from 0, so even counts inside the window are the closed phases.
  assign w_contact = (r_state == PRESS) &&
                     ((r_timer >= CNT_W'(BOUNCE_CYCLES)) || !r_timer[0]);
`else
  assign w_contact = (r_state == PRESS);
`endif

  // Switch matrix: col is not registered so the scanner sees the closure in the same cycle.
  always_comb begin
    row = '0;
    if (w_contact && col[r_key[1:0]]) row[r_key[3:2]] = 1'b1;
  end

  assign key_ready = (r_state == IDLE);
  assign busy      = (r_state == PRESS) || (r_state == GAP);
  assign done      = r_done;

endmodule
